// File: rtl/phase_rms_monitor.sv
// Per-phase RMS over/under-voltage monitor: debounces threshold violations on IEEE-754 samples
// and latches a sticky fault with the offending sample until software clears it.
module phase_rms_monitor #(
   parameter int unsigned P_OV_CNT = 4,
   parameter int unsigned P_UV_CNT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_rms,
   input  logic        i_rms_valid,
   input  logic [31:0] i_ov_th,
   input  logic [31:0] i_uv_th,
   input  logic        i_clr,
   output logic [1:0]  o_state,
   output logic        o_ov_fault,
   output logic        o_uv_fault,
   output logic        o_cfg_err,
   output logic [31:0] o_rms_hold,
   output logic [15:0] o_vio_cnt
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StNormal = 2'd1,
      StWarn   = 2'd2,
      StFault  = 2'd3
   } state_e;

   localparam logic [15:0] OvTrip = 16'(P_OV_CNT);
   localparam logic [15:0] UvTrip = 16'(P_UV_CNT);

   // Negative values (including -0) collapse to zero so magnitudes compare as unsigned.
   function automatic logic [30:0] fp_mag(input logic [31:0] f);
      return f[31] ? 31'd0 : f[30:0];
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   state_e      state_q, state_d;
   logic [15:0] ov_cnt_q, ov_cnt_d;
   logic [15:0] uv_cnt_q, uv_cnt_d;
   logic        ov_fault_q, ov_fault_d;
   logic        uv_fault_q, uv_fault_d;
   logic        cfg_err_q, cfg_err_d;
   logic [31:0] rms_hold_q, rms_hold_d;

   logic [30:0] rms_mag, ov_mag, uv_mag;
   logic        rms_nan, rms_pinf;
   logic        ov_vio, uv_vio;
   logic [15:0] ov_cnt_nxt, uv_cnt_nxt;
   logic        ov_trip, uv_trip;

   always_comb begin
      rms_mag  = fp_mag(i_rms);
      ov_mag   = fp_mag(i_ov_th);
      uv_mag   = fp_mag(i_uv_th);
      rms_nan  = (i_rms[30:23] == 8'hFF) && (i_rms[22:0] != 23'd0);
      rms_pinf = !i_rms[31] && (i_rms[30:23] == 8'hFF) && (i_rms[22:0] == 23'd0);
      ov_vio   = rms_nan || rms_pinf || (rms_mag > ov_mag);
      // A negative NaN has zero magnitude; keep it from also reading as under-voltage.
      uv_vio   = !rms_nan && (rms_mag < uv_mag);
      ov_cnt_nxt = ov_vio ? sat_inc(ov_cnt_q) : 16'd0;
      uv_cnt_nxt = uv_vio ? sat_inc(uv_cnt_q) : 16'd0;
      ov_trip  = ov_vio && (ov_cnt_nxt >= OvTrip);
      uv_trip  = uv_vio && (uv_cnt_nxt >= UvTrip);
   end

   always_comb begin
      state_d    = state_q;
      ov_cnt_d   = ov_cnt_q;
      uv_cnt_d   = uv_cnt_q;
      ov_fault_d = ov_fault_q;
      uv_fault_d = uv_fault_q;
      rms_hold_d = rms_hold_q;
      cfg_err_d  = (uv_mag >= ov_mag);

      if (i_clr) begin
         state_d    = StIdle;
         ov_cnt_d   = 16'd0;
         uv_cnt_d   = 16'd0;
         ov_fault_d = 1'b0;
         uv_fault_d = 1'b0;
         rms_hold_d = 32'd0;
      end else if (cfg_err_d) begin
         // Latched faults survive a bad configuration; only the debounce path is parked.
         state_d  = StIdle;
         ov_cnt_d = 16'd0;
         uv_cnt_d = 16'd0;
      end else if (i_rms_valid) begin
         ov_cnt_d = ov_cnt_nxt;
         uv_cnt_d = uv_cnt_nxt;
         if (state_q != StFault) begin
            if (ov_trip) begin
               state_d    = StFault;
               ov_fault_d = 1'b1;
               rms_hold_d = i_rms;
            end else if (uv_trip) begin
               state_d    = StFault;
               uv_fault_d = 1'b1;
               rms_hold_d = i_rms;
            end else if (ov_vio || uv_vio) begin
               state_d = StWarn;
            end else begin
               state_d = StNormal;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= StIdle;
         ov_cnt_q   <= 16'd0;
         uv_cnt_q   <= 16'd0;
         ov_fault_q <= 1'b0;
         uv_fault_q <= 1'b0;
         cfg_err_q  <= 1'b0;
         rms_hold_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         ov_cnt_q   <= ov_cnt_d;
         uv_cnt_q   <= uv_cnt_d;
         ov_fault_q <= ov_fault_d;
         uv_fault_q <= uv_fault_d;
         cfg_err_q  <= cfg_err_d;
         rms_hold_q <= rms_hold_d;
      end
   end

   assign o_state    = state_q;
   assign o_ov_fault = ov_fault_q;
   assign o_uv_fault = uv_fault_q;
   assign o_cfg_err  = cfg_err_q;
   assign o_rms_hold = rms_hold_q;
   assign o_vio_cnt  = (ov_cnt_q != 16'd0) ? ov_cnt_q : uv_cnt_q;

endmodule

// File: tb/tb_phase_rms_monitor.sv
// Self-checking bench for phase_rms_monitor: table of sample vectors scored through an
// expected-result queue, plus hand-written reset and mid-WARN async reset sequences.
module tb_phase_rms_monitor;

   localparam logic [31:0] F300 = 32'h43960000;
   localparam logic [31:0] F200 = 32'h43480000;
   localparam logic [31:0] F400 = 32'h43C80000;
   localparam logic [31:0] F310 = 32'h439B0000;
   localparam logic [31:0] F250 = 32'h437A0000;
   localparam logic [31:0] F100 = 32'h42C80000;
   localparam logic [31:0] FNAN = 32'h7FC00000;
   localparam logic [31:0] FM5  = 32'hC0A00000;
   localparam logic [31:0] FM0  = 32'h80000000;

   typedef struct {
      logic [1:0]  st;
      logic        ovf;
      logic        uvf;
      logic        cfg;
      logic [31:0] hold;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      logic        clr;
      logic        vld;
      logic [31:0] rms;
      logic [31:0] uv;
      exp_t        e;
   } vec_t;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [31:0] i_rms = 32'd0;
   logic        i_rms_valid = 1'b0;
   logic [31:0] i_ov_th = F300;
   logic [31:0] i_uv_th = F200;
   logic        i_clr = 1'b0;
   logic [1:0]  o_state;
   logic        o_ov_fault;
   logic        o_uv_fault;
   logic        o_cfg_err;
   logic [31:0] o_rms_hold;
   logic [15:0] o_vio_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t sb_q[$];
   vec_t vecs[$];

   phase_rms_monitor #(.P_OV_CNT(4), .P_UV_CNT(4)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_rms       (i_rms),
      .i_rms_valid (i_rms_valid),
      .i_ov_th     (i_ov_th),
      .i_uv_th     (i_uv_th),
      .i_clr       (i_clr),
      .o_state     (o_state),
      .o_ov_fault  (o_ov_fault),
      .o_uv_fault  (o_uv_fault),
      .o_cfg_err   (o_cfg_err),
      .o_rms_hold  (o_rms_hold),
      .o_vio_cnt   (o_vio_cnt)
   );

   always #5 i_clk = ~i_clk;

   function automatic exp_t mk_e(logic [1:0] st, logic ovf, logic uvf, logic cfg,
                                 logic [31:0] hold, logic [15:0] cnt);
      exp_t e;
      e.st = st; e.ovf = ovf; e.uvf = uvf; e.cfg = cfg; e.hold = hold; e.cnt = cnt;
      return e;
   endfunction

   function automatic vec_t mk(logic clr, logic vld, logic [31:0] rms, logic [31:0] uv,
                               exp_t e);
      vec_t v;
      v.clr = clr; v.vld = vld; v.rms = rms; v.uv = uv; v.e = e;
      return v;
   endfunction

   task automatic chk(input string tag, input string fld, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %h, expected %h", tag, fld, got, exp);
      end
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty, got state %0d expected an entry", tag, o_state);
         return;
      end
      e = sb_q.pop_front();
      chk(tag, "state", {30'd0, o_state}, {30'd0, e.st});
      chk(tag, "ov_fault", {31'd0, o_ov_fault}, {31'd0, e.ovf});
      chk(tag, "uv_fault", {31'd0, o_uv_fault}, {31'd0, e.uvf});
      chk(tag, "cfg_err", {31'd0, o_cfg_err}, {31'd0, e.cfg});
      chk(tag, "rms_hold", o_rms_hold, e.hold);
      chk(tag, "vio_cnt", {16'd0, o_vio_cnt}, {16'd0, e.cnt});
   endtask

   initial begin
      // OV trip after four 310 samples, then sticky hold with valid low.
      vecs.push_back(mk(0, 0, 0,    F200, mk_e(0, 0, 0, 0, 0, 0)));
      vecs.push_back(mk(0, 1, F310, F200, mk_e(2, 0, 0, 0, 0, 1)));
      vecs.push_back(mk(0, 1, F310, F200, mk_e(2, 0, 0, 0, 0, 2)));
      vecs.push_back(mk(0, 1, F310, F200, mk_e(2, 0, 0, 0, 0, 3)));
      vecs.push_back(mk(0, 1, F310, F200, mk_e(3, 1, 0, 0, F310, 4)));
      vecs.push_back(mk(0, 0, F250, F200, mk_e(3, 1, 0, 0, F310, 4)));
      // Clear coincident with a valid violating sample: clear wins.
      vecs.push_back(mk(1, 1, F310, F200, mk_e(0, 0, 0, 0, 0, 0)));
      vecs.push_back(mk(0, 1, F310, F200, mk_e(2, 0, 0, 0, 0, 1)));
      vecs.push_back(mk(0, 1, F310, F200, mk_e(2, 0, 0, 0, 0, 2)));
      vecs.push_back(mk(0, 1, F310, F200, mk_e(2, 0, 0, 0, 0, 3)));
      vecs.push_back(mk(0, 1, F250, F200, mk_e(1, 0, 0, 0, 0, 0)));
      vecs.push_back(mk(0, 1, F100, F200, mk_e(2, 0, 0, 0, 0, 1)));
      vecs.push_back(mk(0, 1, F100, F200, mk_e(2, 0, 0, 0, 0, 2)));
      vecs.push_back(mk(0, 1, F100, F200, mk_e(2, 0, 0, 0, 0, 3)));
      vecs.push_back(mk(0, 1, F100, F200, mk_e(3, 0, 1, 0, F100, 4)));
      // In FAULT the counters keep running but flags/hold are frozen.
      vecs.push_back(mk(0, 1, F310, F200, mk_e(3, 0, 1, 0, F100, 1)));
      vecs.push_back(mk(1, 0, 0,    F200, mk_e(0, 0, 0, 0, 0, 0)));
      // NaN -> OV, negatives -> UV, equality -> no violation.
      vecs.push_back(mk(0, 1, FNAN, F200, mk_e(2, 0, 0, 0, 0, 1)));
      vecs.push_back(mk(0, 1, FM5,  F200, mk_e(2, 0, 0, 0, 0, 1)));
      vecs.push_back(mk(0, 1, FM5,  F200, mk_e(2, 0, 0, 0, 0, 2)));
      vecs.push_back(mk(0, 1, FM0,  F200, mk_e(2, 0, 0, 0, 0, 3)));
      vecs.push_back(mk(0, 1, F300, F200, mk_e(1, 0, 0, 0, 0, 0)));
      // Invalid thresholds park the monitor in IDLE and ignore samples.
      vecs.push_back(mk(0, 0, 0,    F400, mk_e(0, 0, 0, 1, 0, 0)));
      vecs.push_back(mk(0, 1, F310, F400, mk_e(0, 0, 0, 1, 0, 0)));
      vecs.push_back(mk(0, 0, 0,    F200, mk_e(0, 0, 0, 0, 0, 0)));
      vecs.push_back(mk(0, 1, F310, F200, mk_e(2, 0, 0, 0, 0, 1)));

      // Reset state while reset is held.
      #12;
      sb_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
      check_out("reset");
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;

      foreach (vecs[i]) begin
         i_clr       = vecs[i].clr;
         i_rms_valid = vecs[i].vld;
         i_rms       = vecs[i].rms;
         i_uv_th     = vecs[i].uv;
         sb_q.push_back(vecs[i].e);
         @(posedge i_clk);
         #1;
         check_out($sformatf("vec%0d", i));
      end

      // Second violating sample, then async reset mid-WARN before the next edge.
      i_clr = 1'b0; i_rms_valid = 1'b1; i_rms = F310; i_uv_th = F200;
      sb_q.push_back(mk_e(2, 0, 0, 0, 0, 2));
      @(posedge i_clk);
      #1;
      check_out("warn2");
      i_rms_valid = 1'b0;
      #1;
      i_rst = 1'b0;
      #1;
      sb_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
      check_out("async_rst");
      @(negedge i_clk);
      i_rst = 1'b1;
      i_rms_valid = 1'b1;
      i_rms = F310;
      sb_q.push_back(mk_e(2, 0, 0, 0, 0, 1));
      @(posedge i_clk);
      #1;
      check_out("post_rst");
      i_rms_valid = 1'b0;

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
